imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction-memory interface the core reads. Receives a byte stream
//   (valid/ready), assembles big-endian 32-bit words, writes them to consecutive imem
//   addresses from 0. Holds the core in reset (cpu_hold) for the whole load. The display
//   path shows load progress via words_loaded.
// PARAMETERS
//   ADDR_WIDTH  8   imem word-address width; capacity DEPTH = 2**ADDR_WIDTH words
// PORTS
//   clock        in   1           system clock, rising edge
//   reset        in   1           asynchronous, active-high
//   load_start   in   1           1-cycle pulse; begins a load when idle
//   byte_in      in   8           stream data
//   byte_valid   in   1           byte_in valid this cycle
//   byte_ready   out  1           loader accepts a byte this cycle
//   imem_we      out  1           imem write strobe, 1 cycle per word
//   imem_addr    out  ADDR_WIDTH  imem word address
//   imem_wdata   out  32          imem write data
//   cpu_hold     out  1           high while loading; ORed into core reset
//   load_done    out  1           1-cycle pulse, load completed
//   load_error   out  1           sticky; header count > DEPTH
//   words_loaded out  16          words written in current/last load
// BEHAVIOUR
//   Reset (async): state IDLE; byte_ready, imem_we, cpu_hold, load_done, load_error = 0;
//     imem_addr, imem_wdata, words_loaded = 0. Memory contents untouched.
//   Handshake: byte taken on rising edge where byte_valid && byte_ready. byte_ready
//     combinational from state: 1 in HDR_HI, HDR_LO, DATA; 0 otherwise. Max 1 byte/cycle.
//   Stream format: count[15:8], count[7:0], then count words, each 4 bytes MSB first
//     (byte0 -> wdata[31:24] ... byte3 -> wdata[7:0]).
//   FSM:
//     IDLE   : load_start -> HDR_HI; clear load_error, words_loaded; cpu_hold <= 1.
//     HDR_HI : byte taken -> count[15:8], -> HDR_LO.
//     HDR_LO : byte taken -> count[7:0]; count==0 -> FIN; count>DEPTH -> ERR; else DATA.
//     DATA   : byte taken -> shift into assembly reg, byte_idx++ (2-bit, wraps).
//              4th byte (idx 3) taken at edge N: cycle after N has imem_we=1,
//              imem_wdata=word, imem_addr=words_loaded[ADDR_WIDTH-1:0]; words_loaded
//              increments at edge N+1. Last word -> FIN; bytes may continue to be
//              accepted during the write cycle (no stall).
//     FIN    : one cycle, load_done=1, cpu_hold<=0 at exit -> IDLE.
//     ERR    : load_error<=1, cpu_hold<=0, no writes, -> IDLE. load_done not pulsed.
//   cpu_hold: registered; high first cycle after load_start accepted through FIN cycle.
//   load_start outside IDLE: ignored. Bytes offered in IDLE: not accepted (ready=0).
//   Exactly DEPTH words: legal; final imem_addr = DEPTH-1; no address wrap ever occurs.
//   Reset mid-load: abort immediately to reset values; partial words already written stay;
//     partially assembled word discarded.
//   No timeout: a stalled stream leaves the loader waiting with cpu_hold high.
// TESTING
//   1. reset; load_start; bytes 00 02 12 34 56 78 9A BC DE F0 -> imem_we at addr 0 data
//      0x12345678, addr 1 data 0x9ABCDEF0; load_done 1 pulse; words_loaded=2; cpu_hold low.
//   2. header 00 00 -> no imem_we; load_done pulse 1 cycle after HDR_LO byte; cpu_hold
//      high exactly from load_start+1 to FIN.
//   3. ADDR_WIDTH=8, header 01 01 (257) -> load_error=1, no imem_we, no load_done;
//      next load_start clears load_error.
//   4. header 01 00, 1024 bytes, byte_valid randomly gapped -> 256 writes, addr 0..255,
//      last addr 0xFF, data matches stream; byte_ready low in IDLE afterwards.
//   5. reset asserted after 6 data bytes of a 2-word load -> all outputs to reset values
//      same cycle; one write (word 0) observed only if 4 bytes completed before reset.
//   6. load_start pulses during DATA -> ignored, words_loaded/addr unaffected.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a byte source and the imem loader.
//   byte_in    : stream data, driven by the source
//   byte_valid : byte_in holds a byte this cycle, driven by the source
//   byte_ready : the loader takes a byte this cycle, driven by the loader
// A byte transfers on the rising edge where byte_valid && byte_ready.
// The master modport is the byte source and the slave modport is the loader.
interface imem_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// It takes a byte stream that starts with a 16-bit big-endian word count. Each word that
// follows is 4 bytes, sent MSB first. The loader assembles each word and writes it to
// consecutive imem word addresses, starting at 0. The core is held in reset (cpu_hold)
// for the whole load.
// Ports:
//   clock, reset  : rising-edge clock and asynchronous active-high reset
//   load_start    : 1-cycle pulse that starts a load when the loader is idle
//   stream        : byte stream handshake (slave side)
//   imem_we       : imem write strobe, high for 1 cycle per word
//   imem_addr     : imem word address for the write
//   imem_wdata    : imem write data for the write
//   cpu_hold      : high while a load is in progress
//   load_done     : 1-cycle pulse when a load completes
//   load_error    : sticky error flag; the header count exceeded the imem depth
//   words_loaded  : number of words written in the current or last load
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    imem_loader_if.slave          stream,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        FIN,
        ERR
    } state_t;

    state_t                state_reg, state_next;
    logic [7:0]            count_hi_reg;
    logic [15:0]           count_reg;
    logic [23:0]           shift_reg;
    logic [1:0]            byte_idx_reg;
    logic                  imem_we_reg;
    logic [ADDR_WIDTH-1:0] imem_addr_reg;
    logic [31:0]           imem_wdata_reg;
    logic                  cpu_hold_reg;
    logic                  load_error_reg;
    logic [15:0]           words_loaded_reg;

    logic                  byte_ready_int;
    logic                  byte_take;
    logic [15:0]           hdr_count;
    logic [31:0]           word_assembled;
    logic                  last_word;

    assign byte_take      = stream.byte_valid && byte_ready_int;
    assign hdr_count      = {count_hi_reg, stream.byte_in};
    assign word_assembled = {shift_reg, stream.byte_in};
    // A word completes at least 4 cycles after the previous one. By then words_loaded
    // has already counted the previous write, so it is safe to use it here.
    assign last_word      = ({1'b0, words_loaded_reg} + 17'd1) == {1'b0, count_reg};

    always_comb begin
        state_next     = state_reg;
        byte_ready_int = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_start) state_next = HDR_HI;
            end
            HDR_HI: begin
                byte_ready_int = 1'b1;
                if (stream.byte_valid) state_next = HDR_LO;
            end
            HDR_LO: begin
                byte_ready_int = 1'b1;
                if (stream.byte_valid) begin
                    if (hdr_count == 16'd0)
                        state_next = FIN;
                    else if ({16'd0, hdr_count} > DEPTH)
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                byte_ready_int = 1'b1;
                if (stream.byte_valid && byte_idx_reg == 2'd3 && last_word)
                    state_next = FIN;
            end
            FIN:     state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            count_hi_reg     <= 8'd0;
            count_reg        <= 16'd0;
            shift_reg        <= 24'd0;
            byte_idx_reg     <= 2'd0;
            imem_we_reg      <= 1'b0;
            imem_addr_reg    <= '0;
            imem_wdata_reg   <= 32'd0;
            cpu_hold_reg     <= 1'b0;
            load_error_reg   <= 1'b0;
            words_loaded_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            imem_we_reg <= 1'b0;
            // The count advances on the edge that ends the write cycle.
            if (imem_we_reg)
                words_loaded_reg <= words_loaded_reg + 16'd1;
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        cpu_hold_reg     <= 1'b1;
                        load_error_reg   <= 1'b0;
                        words_loaded_reg <= 16'd0;
                        byte_idx_reg     <= 2'd0;
                    end
                end
                HDR_HI: begin
                    if (byte_take) count_hi_reg <= stream.byte_in;
                end
                HDR_LO: begin
                    if (byte_take) begin
                        count_reg    <= hdr_count;
                        byte_idx_reg <= 2'd0;
                    end
                end
                DATA: begin
                    if (byte_take) begin
                        shift_reg    <= {shift_reg[15:0], stream.byte_in};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            imem_we_reg    <= 1'b1;
                            imem_wdata_reg <= word_assembled;
                            imem_addr_reg  <= words_loaded_reg[ADDR_WIDTH-1:0];
                        end
                    end
                end
                FIN: begin
                    cpu_hold_reg <= 1'b0;
                end
                ERR: begin
                    load_error_reg <= 1'b1;
                    cpu_hold_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign stream.byte_ready = byte_ready_int;
    assign imem_we           = imem_we_reg;
    assign imem_addr         = imem_addr_reg;
    assign imem_wdata        = imem_wdata_reg;
    assign cpu_hold          = cpu_hold_reg;
    assign load_done         = (state_reg == FIN);
    assign load_error        = load_error_reg;
    assign words_loaded      = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with ADDR_WIDTH = 8 (imem depth 256).
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        load_start;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_loader_if stream_if();

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_start   (load_start),
        .stream       (stream_if.slave),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Write and done capture, sampled away from the active edge.
    logic [7:0]  addr_q[$];
    logic [31:0] data_q[$];
    int          done_cnt = 0;

    always @(negedge clock) begin
        if (imem_we) begin
            addr_q.push_back(imem_addr);
            data_q.push_back(imem_wdata);
        end
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        load_start = 1'b1;
        @(posedge clock); #1;
        load_start = 1'b0;
    endtask

    // Offer one byte and hold it until it is taken; return at #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        stream_if.byte_in    = b;
        stream_if.byte_valid = 1'b1;
        @(negedge clock);
        while (!stream_if.byte_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!stream_if.byte_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        stream_if.byte_valid = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'(k * 37 + 11);
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(stream_if.byte_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we),              32'd0);
        check({tag, "_addr"},  32'(imem_addr),            32'd0);
        check({tag, "_wdata"}, imem_wdata,                32'd0);
        check({tag, "_hold"},  32'(cpu_hold),             32'd0);
        check({tag, "_done"},  32'(load_done),            32'd0);
        check({tag, "_err"},   32'(load_error),           32'd0);
        check({tag, "_words"}, 32'(words_loaded),         32'd0);
    endtask

    initial begin
        int wr_base;
        int done_base;
        logic [31:0] exp_word;
        logic [7:0]  t1_bytes [10];
        logic [7:0]  t5_bytes [8];
        logic [7:0]  t6_bytes [10];

        t1_bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        t5_bytes = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        t6_bytes = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        reset                = 1'b1;
        load_start           = 1'b0;
        stream_if.byte_in    = 8'h00;
        stream_if.byte_valid = 1'b0;

        // Reset state
        #12;
        check_reset_values("rst");
        @(posedge clock); #1;
        reset = 1'b0;
        $display("reset: outputs checked");

        // Test 1: two-word load
        wr_base   = addr_q.size();
        done_base = done_cnt;
        pulse_start();
        check("t1_hold_start", 32'(cpu_hold), 32'd1);
        foreach (t1_bytes[i]) send_byte(t1_bytes[i]);
        check("t1_done_pulse", 32'(load_done), 32'd1);
        check("t1_we_last",    32'(imem_we),   32'd1);
        @(posedge clock); #1;
        check("t1_words",  32'(words_loaded),             32'd2);
        check("t1_hold",   32'(cpu_hold),                 32'd0);
        check("t1_done_n", 32'(done_cnt - done_base),     32'd1);
        check("t1_nwr",    32'(addr_q.size() - wr_base),  32'd2);
        if (addr_q.size() - wr_base == 2) begin
            check("t1_a0", 32'(addr_q[wr_base]),   32'd0);
            check("t1_d0", data_q[wr_base],        32'h12345678);
            check("t1_a1", 32'(addr_q[wr_base+1]), 32'd1);
            check("t1_d1", data_q[wr_base+1],      32'h9ABCDEF0);
        end
        $display("load 1: 2-word stream, %0d writes", addr_q.size() - wr_base);

        // Test 2: empty load
        wr_base   = addr_q.size();
        done_base = done_cnt;
        check("t2_hold_pre", 32'(cpu_hold), 32'd0);
        pulse_start();
        check("t2_hold_start", 32'(cpu_hold), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t2_done_fin", 32'(load_done), 32'd1);
        check("t2_hold_fin", 32'(cpu_hold),  32'd1);
        @(posedge clock); #1;
        check("t2_done_after", 32'(load_done),                32'd0);
        check("t2_hold_after", 32'(cpu_hold),                 32'd0);
        check("t2_nwr",        32'(addr_q.size() - wr_base),  32'd0);
        check("t2_done_n",     32'(done_cnt - done_base),     32'd1);
        check("t2_words",      32'(words_loaded),             32'd0);
        $display("load 2: empty stream");

        // Test 3: oversize header
        wr_base   = addr_q.size();
        done_base = done_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        @(posedge clock); #1;
        check("t3_err",    32'(load_error),               32'd1);
        check("t3_hold",   32'(cpu_hold),                 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("t3_err_sticky", 32'(load_error),           32'd1);
        check("t3_nwr",    32'(addr_q.size() - wr_base),  32'd0);
        check("t3_done_n", 32'(done_cnt - done_base),     32'd0);
        pulse_start();
        check("t3_err_clr", 32'(load_error), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        $display("load 3: header 257 rejected");

        // Test 4: full-depth load with gapped stream
        wr_base   = addr_q.size();
        done_base = done_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 1024; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1;
            end
            send_byte(pat(k));
        end
        check("t4_done_fin", 32'(load_done), 32'd1);
        @(posedge clock); #1;
        check("t4_words",  32'(words_loaded),             32'd256);
        check("t4_done_n", 32'(done_cnt - done_base),     32'd1);
        check("t4_nwr",    32'(addr_q.size() - wr_base),  32'd256);
        if (addr_q.size() - wr_base == 256) begin
            for (int i = 0; i < 256; i++) begin
                exp_word = {pat(4*i), pat(4*i+1), pat(4*i+2), pat(4*i+3)};
                check($sformatf("t4_a%0d", i), 32'(addr_q[wr_base+i]), 32'(i));
                check($sformatf("t4_d%0d", i), data_q[wr_base+i],      exp_word);
            end
            check("t4_last_addr", 32'(addr_q[wr_base+255]), 32'h0000_00FF);
        end
        stream_if.byte_in    = 8'h55;
        stream_if.byte_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("t4_idle_ready", 32'(stream_if.byte_ready),     32'd0);
        check("t4_idle_hold",  32'(cpu_hold),                 32'd0);
        check("t4_idle_words", 32'(words_loaded),             32'd256);
        check("t4_idle_nwr",   32'(addr_q.size() - wr_base),  32'd256);
        stream_if.byte_valid = 1'b0;
        $display("load 4: 256-word stream, %0d writes", addr_q.size() - wr_base);

        // Test 5: reset after 6 data bytes
        wr_base = addr_q.size();
        pulse_start();
        foreach (t5_bytes[i]) send_byte(t5_bytes[i]);
        reset = 1'b1;
        #1;
        check_reset_values("t5_rst");
        @(posedge clock); #1;
        reset = 1'b0;
        check("t5_nwr", 32'(addr_q.size() - wr_base), 32'd1);
        if (addr_q.size() - wr_base == 1) begin
            check("t5_a0", 32'(addr_q[wr_base]), 32'd0);
            check("t5_d0", data_q[wr_base],      32'hAABBCCDD);
        end
        wr_base = addr_q.size();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        @(posedge clock); #1;
        check("t5_reload_nwr", 32'(addr_q.size() - wr_base), 32'd1);
        if (addr_q.size() - wr_base == 1) begin
            check("t5_reload_a", 32'(addr_q[wr_base]), 32'd0);
            check("t5_reload_d", data_q[wr_base],      32'h01020304);
        end
        $display("load 5: reset mid-load, then 1-word reload");

        // Test 6: load_start pulses during DATA
        wr_base   = addr_q.size();
        done_base = done_cnt;
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(t6_bytes[i]);
        pulse_start();
        check("t6_hold",  32'(cpu_hold),     32'd1);
        check("t6_words", 32'(words_loaded), 32'd1);
        for (int i = 7; i < 10; i++) send_byte(t6_bytes[i]);
        @(posedge clock); #1;
        check("t6_words_end", 32'(words_loaded),             32'd2);
        check("t6_done_n",    32'(done_cnt - done_base),     32'd1);
        check("t6_nwr",       32'(addr_q.size() - wr_base),  32'd2);
        if (addr_q.size() - wr_base == 2) begin
            check("t6_a0", 32'(addr_q[wr_base]),   32'd0);
            check("t6_d0", data_q[wr_base],        32'h11223344);
            check("t6_a1", 32'(addr_q[wr_base+1]), 32'd1);
            check("t6_d1", data_q[wr_base+1],      32'h55667788);
        end
        $display("load 6: load_start during DATA ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
